// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dispatch stage.
// Queue entries carry the raw instruction, its pc and predicted-taken bit.
package dispatch_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN_DEF-1:0] inst;
    logic [XLEN_DEF-1:0] pc;
    logic                pred;
  } q_entry_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Circular buffer with occupancy count and synchronous clear.
// clr wins over en so a flush empties the queue even when stalled.
module dispatch_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = en && push && !full;
  assign do_pop  = en && pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem[wp] <= wdata;
  end

endmodule

// File: rtl/dispatch_queue_unit.sv
// Dispatch stage: buffers fetched instructions, resolves operands,
// allocates a ROB tag and issues one registered packet to RS or LSB.
module dispatch_queue_unit
  import dispatch_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int NUM_CDB = 2,
  parameter int QDEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [XLEN-1:0]          if_inst,
  input  logic [XLEN-1:0]          if_pc,
  input  logic                     if_pred,
  output logic [XLEN-1:0]          parse_inst,
  input  logic                     dec_is_ls,
  input  logic [4:0]               dec_rd,
  input  logic [4:0]               dec_rs1,
  input  logic [4:0]               dec_rs2,
  input  logic [6:0]               dec_op,
  input  logic [XLEN-1:0]          dec_imm,
  output logic [4:0]               rf_rs1,
  output logic [4:0]               rf_rs2,
  input  logic                     rf_busy1,
  input  logic                     rf_busy2,
  input  logic [TAG_W-1:0]         rf_tag1,
  input  logic [TAG_W-1:0]         rf_tag2,
  input  logic [XLEN-1:0]          rf_val1,
  input  logic [XLEN-1:0]          rf_val2,
  output logic [TAG_W-1:0]         rob_qry1,
  output logic [TAG_W-1:0]         rob_qry2,
  input  logic                     rob_rdy1,
  input  logic                     rob_rdy2,
  input  logic [XLEN-1:0]          rob_val1,
  input  logic [XLEN-1:0]          rob_val2,
  input  logic                     rob_full,
  input  logic                     rs_full,
  input  logic                     lsb_full,
  input  logic [TAG_W-1:0]         rob_free_tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  output logic                     rob_alloc,
  output logic                     iss_rs_valid,
  output logic                     iss_lsb_valid,
  output logic [6:0]               iss_op,
  output logic [XLEN-1:0]          iss_imm,
  output logic [XLEN-1:0]          iss_pc,
  output logic [4:0]               iss_rd,
  output logic [TAG_W-1:0]         iss_tag,
  output logic                     iss_pred,
  output logic                     iss_q1_busy,
  output logic                     iss_q2_busy,
  output logic [TAG_W-1:0]         iss_q1,
  output logic [TAG_W-1:0]         iss_q2,
  output logic [XLEN-1:0]          iss_v1,
  output logic [XLEN-1:0]          iss_v2,
  output logic                     ren_valid,
  output logic [4:0]               ren_rd,
  output logic [TAG_W-1:0]         ren_tag
);

  localparam int CW = $clog2(QDEPTH) + 1;

  q_entry_t      wr_ent;
  q_entry_t      head;
  logic [CW-1:0] q_count;
  logic          q_empty;
  logic          q_full;
  logic          push;
  logic          issue;
  logic          unit_ok;
  logic [XLEN:0] op1;
  logic [XLEN:0] op2;

  // Returns {busy, value}; lower CDB channels take priority.
  function automatic logic [XLEN:0] resolve(
    input logic [4:0]               idx,
    input logic                     busy,
    input logic [TAG_W-1:0]         tag,
    input logic [XLEN-1:0]          rfv,
    input logic                     rrdy,
    input logic [XLEN-1:0]          rv,
    input logic [NUM_CDB-1:0]       cv,
    input logic [NUM_CDB*TAG_W-1:0] ct,
    input logic [NUM_CDB*XLEN-1:0]  cval
  );
    logic [XLEN:0] r;
    r = {1'b0, rfv};
    if (idx != '0 && busy) begin
      if (rrdy) begin
        r = {1'b0, rv};
      end else begin
        r = {1'b1, {XLEN{1'b0}}};
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
          if (cv[i] && ct[i*TAG_W +: TAG_W] == tag)
            r = {1'b0, cval[i*XLEN +: XLEN]};
        end
      end
    end
    return r;
  endfunction

  assign wr_ent     = '{inst: if_inst, pc: if_pc, pred: if_pred};
  assign q_full     = q_count == CW'(QDEPTH);
  assign if_ready   = !q_full && !flush;
  assign push       = if_valid && if_ready;
  assign parse_inst = head.inst;
  assign rf_rs1     = dec_rs1;
  assign rf_rs2     = dec_rs2;
  assign rob_qry1   = rf_tag1;
  assign rob_qry2   = rf_tag2;
  assign unit_ok    = dec_is_ls ? !lsb_full : !rs_full;
  assign issue      = rdy && !rst && !flush && !q_empty
                   && !rob_full && unit_ok;

  assign op1 = resolve(dec_rs1, rf_busy1, rf_tag1, rf_val1,
                       rob_rdy1, rob_val1,
                       cdb_valid, cdb_tag, cdb_value);
  assign op2 = resolve(dec_rs2, rf_busy2, rf_tag2, rf_val2,
                       rob_rdy2, rob_val2,
                       cdb_valid, cdb_tag, cdb_value);

  dispatch_fifo #(
    .W     ($bits(q_entry_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .en    (rdy),
    .push  (push),
    .pop   (issue),
    .wdata (wr_ent),
    .rdata (head),
    .count (q_count),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_alloc     <= 1'b0;
      iss_rs_valid  <= 1'b0;
      iss_lsb_valid <= 1'b0;
      ren_valid     <= 1'b0;
      iss_op        <= '0;
      iss_imm       <= '0;
      iss_pc        <= '0;
      iss_rd        <= '0;
      iss_tag       <= '0;
      iss_pred      <= 1'b0;
      iss_q1_busy   <= 1'b0;
      iss_q2_busy   <= 1'b0;
      iss_q1        <= '0;
      iss_q2        <= '0;
      iss_v1        <= '0;
      iss_v2        <= '0;
      ren_rd        <= '0;
      ren_tag       <= '0;
    end else begin
      rob_alloc     <= issue;
      iss_rs_valid  <= issue && !dec_is_ls;
      iss_lsb_valid <= issue && dec_is_ls;
      ren_valid     <= issue && dec_rd != 5'd0;
      if (issue) begin
        iss_op      <= dec_op;
        iss_imm     <= dec_imm;
        iss_pc      <= head.pc;
        iss_rd      <= dec_rd;
        iss_tag     <= rob_free_tag;
        iss_pred    <= head.pred;
        iss_q1_busy <= op1[XLEN];
        iss_q2_busy <= op2[XLEN];
        iss_q1      <= rf_tag1;
        iss_q2      <= rf_tag2;
        iss_v1      <= op1[XLEN-1:0];
        iss_v2      <= op2[XLEN-1:0];
        ren_rd      <= dec_rd;
        ren_tag     <= rob_free_tag;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue_unit.sv
// Directed plus randomized bench for dispatch_queue_unit with a
// queue-based reference model of fetch, issue and operand resolution.
module tb_dispatch_queue_unit;
  import dispatch_pkg::*;

  localparam int XLEN = 32, TAG_W = 5, NUM_CDB = 2, QDEPTH = 4;

  logic clk, rst, rdy, flush;
  logic if_valid, if_ready, if_pred;
  logic [31:0] if_inst, if_pc, parse_inst, dec_imm;
  logic dec_is_ls;
  logic [4:0] dec_rd, dec_rs1, dec_rs2, rf_rs1, rf_rs2;
  logic [6:0] dec_op;
  logic rf_busy1, rf_busy2, rob_rdy1, rob_rdy2;
  logic [4:0] rf_tag1, rf_tag2, rob_qry1, rob_qry2, rob_free_tag;
  logic [31:0] rf_val1, rf_val2, rob_val1, rob_val2;
  logic rob_full, rs_full, lsb_full;
  logic [1:0] cdb_valid;
  logic [9:0] cdb_tag;
  logic [63:0] cdb_value;
  logic rob_alloc, iss_rs_valid, iss_lsb_valid, iss_pred;
  logic [6:0] iss_op;
  logic [31:0] iss_imm, iss_pc, iss_v1, iss_v2;
  logic [4:0] iss_rd, iss_tag, iss_q1, iss_q2, ren_rd, ren_tag;
  logic iss_q1_busy, iss_q2_busy, ren_valid;

  int tests_run = 0;
  int tests_failed = 0;

  q_entry_t mq[$];
  logic [31:0] dut_pcs[$];
  logic e_alloc, e_rs, e_lsb, e_ren;
  logic [199:0] e_pay;
  logic [9:0] e_rdtag;
  logic [6:0] ops [4];

  dispatch_queue_unit #(
    .XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
    .if_pc(if_pc), .if_pred(if_pred), .parse_inst(parse_inst),
    .dec_is_ls(dec_is_ls), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_op(dec_op), .dec_imm(dec_imm),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_busy1(rf_busy1), .rf_busy2(rf_busy2),
    .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
    .rf_val1(rf_val1), .rf_val2(rf_val2),
    .rob_qry1(rob_qry1), .rob_qry2(rob_qry2),
    .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2),
    .rob_val1(rob_val1), .rob_val2(rob_val2),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_free_tag(rob_free_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .rob_alloc(rob_alloc), .iss_rs_valid(iss_rs_valid),
    .iss_lsb_valid(iss_lsb_valid), .iss_op(iss_op),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rd(iss_rd),
    .iss_tag(iss_tag), .iss_pred(iss_pred),
    .iss_q1_busy(iss_q1_busy), .iss_q2_busy(iss_q2_busy),
    .iss_q1(iss_q1), .iss_q2(iss_q2),
    .iss_v1(iss_v1), .iss_v2(iss_v2),
    .ren_valid(ren_valid), .ren_rd(ren_rd), .ren_tag(ren_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External decoder fed from the queue head.
  always_comb begin
    dec_op    = parse_inst[6:0];
    dec_rd    = parse_inst[11:7];
    dec_rs1   = parse_inst[19:15];
    dec_rs2   = parse_inst[24:20];
    dec_imm   = {{20{parse_inst[31]}}, parse_inst[31:20]};
    dec_is_ls = dec_op == OP_LOAD || dec_op == OP_STORE;
  end

  task automatic chk(string tag, logic [199:0] obs, logic [199:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd,
                                     logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic is_ls(logic [31:0] inst);
    return inst[6:0] == OP_LOAD || inst[6:0] == OP_STORE;
  endfunction

  // Operand source rules: RF, then ROB, then first matching CDB channel.
  task automatic resolve_m(input logic [4:0] idx, input logic busy,
                           input logic [4:0] tag, input logic [31:0] rfv,
                           input logic rrdy, input logic [31:0] rv,
                           output logic ob, output logic [4:0] oq,
                           output logic [31:0] ov);
    bit found;
    ob = 1'b0; oq = tag; ov = rfv;
    if (idx != 0 && busy) begin
      if (rrdy) ov = rv;
      else begin
        found = 0; ob = 1'b1; ov = 32'd0;
        for (int i = 0; i < NUM_CDB; i++) begin
          if (!found && cdb_valid[i] && cdb_tag[i*5 +: 5] == tag) begin
            found = 1; ob = 1'b0; ov = cdb_value[i*32 +: 32];
          end
        end
      end
    end
  endtask

  function automatic logic [199:0] dut_pay();
    return 200'({iss_op, iss_imm, iss_pc, iss_rd, iss_tag, iss_pred,
                 iss_q1_busy, iss_q1 & {5{iss_q1_busy}}, iss_v1,
                 iss_q2_busy, iss_q2 & {5{iss_q2_busy}}, iss_v2});
  endfunction

  // One clock: model predicts, edge, then compare. Called at negedge.
  task automatic cycle();
    q_entry_t h;
    logic b1, b2;
    logic [4:0] q1, q2;
    logic [31:0] v1, v2;
    logic do_iss;
    #1;
    chk("if_ready", 200'(if_ready), 200'(mq.size() < QDEPTH && !flush));
    chk("rob_qry1", 200'(rob_qry1), 200'(rf_tag1));
    if (mq.size() > 0) begin
      chk("parse_inst", 200'(parse_inst), 200'(mq[0].inst));
      chk("rf_rs", 200'({rf_rs1, rf_rs2}),
          200'({mq[0].inst[19:15], mq[0].inst[24:20]}));
    end
    if (rst) begin
      mq.delete();
      {e_alloc, e_rs, e_lsb, e_ren} = '0;
      e_pay = '0; e_rdtag = '0;
    end else if (flush || !rdy) begin
      if (flush) mq.delete();
      {e_alloc, e_rs, e_lsb, e_ren} = '0;
    end else begin
      do_iss = mq.size() > 0 && !rob_full &&
               (is_ls(mq[0].inst) ? !lsb_full : !rs_full);
      {e_alloc, e_rs, e_lsb, e_ren} = '0;
      if (do_iss) begin
        h = mq.pop_front();
        resolve_m(h.inst[19:15], rf_busy1, rf_tag1, rf_val1,
                  rob_rdy1, rob_val1, b1, q1, v1);
        resolve_m(h.inst[24:20], rf_busy2, rf_tag2, rf_val2,
                  rob_rdy2, rob_val2, b2, q2, v2);
        e_alloc = 1; e_rs = !is_ls(h.inst); e_lsb = is_ls(h.inst);
        e_ren = h.inst[11:7] != 0;
        e_rdtag = {h.inst[11:7], rob_free_tag};
        e_pay = 200'({h.inst[6:0], {{20{h.inst[31]}}, h.inst[31:20]},
                      h.pc, h.inst[11:7], rob_free_tag, h.pred,
                      b1, q1 & {5{b1}}, v1, b2, q2 & {5{b2}}, v2});
      end
      if (if_valid && (mq.size() + (do_iss ? 1 : 0)) < QDEPTH)
        mq.push_back('{inst: if_inst, pc: if_pc, pred: if_pred});
    end
    @(posedge clk);
    #1;
    chk("rob_alloc", 200'(rob_alloc), 200'(e_alloc));
    chk("iss_rs_valid", 200'(iss_rs_valid), 200'(e_rs));
    chk("iss_lsb_valid", 200'(iss_lsb_valid), 200'(e_lsb));
    chk("ren_valid", 200'(ren_valid), 200'(e_ren));
    chk("payload", dut_pay(), e_pay);
    if (e_ren) chk("ren_rd_tag", 200'({ren_rd, ren_tag}), 200'(e_rdtag));
    if (rob_alloc === 1'b1) dut_pcs.push_back(iss_pc);
    @(negedge clk);
  endtask

  task automatic set_idle();
    if_valid = 0; if_inst = 0; if_pc = 0; if_pred = 0;
    rf_busy1 = 0; rf_busy2 = 0; rf_tag1 = 0; rf_tag2 = 0;
    rf_val1 = 0; rf_val2 = 0; rob_rdy1 = 0; rob_rdy2 = 0;
    rob_val1 = 0; rob_val2 = 0; rob_full = 0; rs_full = 0;
    lsb_full = 0; rob_free_tag = 0; cdb_valid = 0; cdb_tag = 0;
    cdb_value = 0; flush = 0; rdy = 1;
  endtask

  initial begin
    logic [31:0] r;
    ops = '{OP_IMM, OP_REG, OP_LOAD, OP_STORE};
    set_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 0;

    // addi x1,x0,5 at pc 0
    if_valid = 1; if_inst = 32'h0050_0093; if_pc = 0; rob_free_tag = 5'd9;
    cycle();
    if_valid = 0;
    cycle();
    chk("t1_rs_valid", 200'(iss_rs_valid), 200'(1));
    chk("t1_rd_imm", 200'({iss_rd, iss_imm}), 200'({5'd1, 32'd5}));
    chk("t1_v1", 200'({iss_q1_busy, iss_v1}), 200'(0));
    chk("t1_ren", 200'({ren_valid, ren_tag}), 200'({1'b1, 5'd9}));

    // lw blocked by lsb_full while the queue fills
    lsb_full = 1;
    for (int i = 0; i < 4; i++) begin
      if_valid = 1; if_pc = 32'h10 + 32'(4 * i);
      if_inst = (i == 0) ? mk(OP_LOAD, 5'd2, 5'd1, 5'd0)
                         : mk(OP_IMM, 5'(i + 3), 5'd0, 5'd1);
      cycle();
    end
    if_valid = 0;
    #1 chk("t2_full", 200'(if_ready), 200'(0));
    lsb_full = 0;
    cycle();
    chk("t2_lsb", 200'({iss_lsb_valid, iss_pc}), 200'({1'b1, 32'h10}));
    #1 chk("t2_ready", 200'(if_ready), 200'(1));
    repeat (3) cycle();

    // CDB resolves rs1, channel 0 wins
    if_valid = 1; if_inst = mk(OP_REG, 5'd3, 5'd5, 5'd0); cycle();
    if_valid = 0; rf_busy1 = 1; rf_tag1 = 5'd7; cdb_valid = 2'b11;
    cdb_tag = {5'd7, 5'd7}; cdb_value = {32'hBB, 32'hAA};
    cycle();
    chk("t3_v1", 200'({iss_q1_busy, iss_v1}), 200'({1'b0, 32'hAA}));
    set_idle();

    // rs2 pending with no producer result
    if_valid = 1; if_inst = mk(OP_REG, 5'd4, 5'd0, 5'd6); cycle();
    if_valid = 0; rf_busy2 = 1; rf_tag2 = 5'd3;
    cdb_valid = 2'b11; cdb_tag = {5'd7, 5'd1};
    cycle();
    chk("t4_q2", 200'({iss_q2_busy, iss_q2}), 200'({1'b1, 5'd3}));
    set_idle();

    // flush with three entries during an issue cycle
    rs_full = 1;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1; if_pc = 32'h40 + 32'(4 * i);
      if_inst = mk(OP_IMM, 5'd5, 5'd0, 5'd2); cycle();
    end
    if_valid = 0; rs_full = 0; flush = 1;
    cycle();
    chk("t5_flush", 200'(rob_alloc), 200'(0));
    flush = 0;
    cycle();
    chk("t5_empty", 200'(rob_alloc), 200'(0));
    if_valid = 1; if_pc = 32'h80; cycle();
    if_valid = 0; cycle();
    chk("t5_after", 200'({rob_alloc, iss_pc}), 200'({1'b1, 32'h80}));

    // nine back-to-back instructions, pointers wrap twice
    dut_pcs.delete();
    for (int i = 0; i < 9; i++) begin
      if_valid = 1; if_pc = 32'h100 + 32'(4 * i);
      if_inst = mk(OP_IMM, 5'(i + 1), 5'd0, 5'(i)); cycle();
    end
    if_valid = 0;
    repeat (3) cycle();
    chk("t6_count", 200'(dut_pcs.size()), 200'(9));
    for (int i = 0; i < dut_pcs.size(); i++)
      chk("t6_order", 200'(dut_pcs[i]), 200'(32'h100 + 32'(4 * i)));

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 99) == 0;
      flush = $urandom_range(0, 24) == 0;
      rdy = $urandom_range(0, 7) != 0;
      if_valid = 1'($urandom_range(0, 1));
      r = $urandom();
      if_inst = {r[31:7], ops[$urandom_range(0, 3)]};
      if_pc = $urandom(); if_pred = 1'($urandom_range(0, 1));
      rf_busy1 = 1'($urandom_range(0, 1)); rf_busy2 = 1'($urandom_range(0, 1));
      rf_tag1 = 5'($urandom_range(0, 7)); rf_tag2 = 5'($urandom_range(0, 7));
      rf_val1 = $urandom(); rf_val2 = $urandom();
      rob_rdy1 = $urandom_range(0, 3) == 0; rob_rdy2 = $urandom_range(0, 3) == 0;
      rob_val1 = $urandom(); rob_val2 = $urandom();
      rob_full = $urandom_range(0, 5) == 0;
      rs_full = $urandom_range(0, 3) == 0;
      lsb_full = $urandom_range(0, 3) == 0;
      rob_free_tag = 5'($urandom());
      cdb_valid = 2'($urandom_range(0, 3));
      cdb_tag = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      cdb_value = {$urandom(), $urandom()};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dispatch_queue_unit.md
Name: dispatch_queue_unit

Overview:
Parametrised dispatch stage between instruction fetch and the out-of-order back end (ROB, ALU reservation station, load/store buffer, register file). A QDEPTH-entry instruction queue decouples fetch from back-pressure. Each cycle the block resolves the head instruction's operands from the RF, the ROB and NUM_CDB result-broadcast channels, then issues it. Each issue allocates a ROB entry, renames rd, and sends one registered packet to either the RS or the LSB.

Parameters:
XLEN, 32, data/address width
TAG_W, 5, ROB tag width
NUM_CDB, 2, number of result-broadcast channels snooped
QDEPTH, 4, instruction queue entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; when 0 all state holds
flush  in  1  mispredict flush
if_valid / if_ready  in / out  1  fetch handshake; transfer when both 1
if_inst, if_pc  in  XLEN  fetched instruction, pc
if_pred  in  1  predicted-taken bit
parse_inst  out  XLEN  queue-head instruction to combinational decoder
dec_is_ls  in  1  head is load/store
dec_rd, dec_rs1, dec_rs2  in  5  decoded register indices
dec_op  in  7  opcode
dec_imm  in  XLEN  immediate
rf_rs1 / rf_rs2  out  5  RF read indices (= dec_rs1/dec_rs2)
rf_busy1 / rf_busy2  in  1  RF register renamed
rf_tag1 / rf_tag2  in  TAG_W  RF rename tag
rf_val1 / rf_val2  in  XLEN  RF committed value
rob_qry1 / rob_qry2  out  TAG_W  ROB lookup tags (= rf_tag1/rf_tag2)
rob_rdy1 / rob_rdy2  in  1  ROB entry has result
rob_val1 / rob_val2  in  XLEN  ROB result
rob_full, rs_full, lsb_full  in  1  almost-full flags: at least 2 free slots remain when 0
rob_free_tag  in  TAG_W  tag the ROB assigns to the next allocation
cdb_valid  in  NUM_CDB  broadcast valids
cdb_tag  in  NUM_CDB*TAG_W  broadcast tags, channel i at [i*TAG_W +: TAG_W]
cdb_value  in  NUM_CDB*XLEN  broadcast values
rob_alloc  out  1  ROB allocate pulse
iss_rs_valid / iss_lsb_valid  out  1  RS / LSB issue pulses
iss_op  out  7  shared payload: opcode
iss_imm, iss_pc  out  XLEN  shared payload: immediate, pc
iss_rd  out  5  shared payload: destination register
iss_tag  out  TAG_W  shared payload: allocated ROB tag
iss_pred  out  1  shared payload: predicted-taken bit
iss_q1_busy / iss_q2_busy  out  1  shared payload: operand pending
iss_q1 / iss_q2  out  TAG_W  shared payload: producer tag
iss_v1 / iss_v2  out  XLEN  shared payload: operand value
ren_valid  out  1  RF rename write
ren_rd  out  5  RF rename register
ren_tag  out  TAG_W  RF rename tag

Behaviour:
- Reset: queue empty, all outputs registered 0. if_ready is combinational: not full and not flush.
- Enqueue: if_valid && if_ready at edge N writes tail. Earliest issue is at edge N+1, so outputs are visible after N+1 (2-cycle fetch-to-issue). The queue is not bypassed.
- Issue condition: queue non-empty && !rob_full && (dec_is_ls ? !lsb_full : !rs_full) && !flush. On issue, pop the head and register one cycle of rob_alloc=1 with exactly one of iss_rs_valid/iss_lsb_valid=1.
- ren_valid=1 when dec_rd!=0. ren_tag = iss_tag = rob_free_tag.
- All valid pulses are one cycle; if no issue they are 0 next cycle. The payload holds its last value.
- Simultaneous push and pop when full: not allowed, because if_ready=0 when full. Push and pop when non-full: both happen and the count is unchanged. Pointers wrap modulo QDEPTH. The count is log2(QDEPTH)+1 bits.
- Operand resolution, per source, in priority order:
  (a) rs index 0 or !rf_busy → busy=0, value=rf_val.
  (b) rob_rdy → busy=0, value=rob_val.
  (c) a cdb channel is valid and its tag equals rf_tag → busy=0, value=its value; the lowest channel index wins.
  (d) otherwise busy=1, tag=rf_tag, value=0.
- Issue-cycle CDB wakeup: if a cdb tag matches the value being registered as pending, it is resolved in the same cycle. Nothing else is tracked after issue.
- Flush (rdy-independent, like rst): empties the queue, clears all valid outputs, and inhibits issue and enqueue that cycle.
- rst or flush in the middle of an issue drops that issue.
- rdy=0: pointers, count and outputs hold. Valid pulses are forced to 0.

Decomposition:
- Shared package dispatch_pkg holds: opcode constants, TAG_W/XLEN defaults, and the queue-entry struct {inst, pc, pred}.
- One sub-module, dispatch_fifo: a parametrised circular buffer with count, full/empty and synchronous clear.

Test Plan:
1. Reset, then push addi x1,x0,5 at pc 0x0 → two edges later rob_alloc=1, iss_rs_valid=1, iss_rd=1, iss_v1=0, iss_q1_busy=0, iss_imm=5, ren_valid=1.
2. lw head with lsb_full=1 for 3 cycles → no issue; the queue fills to 4 and if_ready=0. Deassert lsb_full → iss_lsb_valid next edge, and if_ready=1.
3. rf_busy1=1, rf_tag1=7, rob_rdy1=0, cdb_valid=2'b11, cdb_tag={7,7}, cdb_value={0xBB,0xAA} → iss_q1_busy=0, iss_v1=0xAA.
4. rf_busy2=1, tag 3, no match anywhere → iss_q2_busy=1, iss_q2=3.
5. Queue holds 3 entries and flush is asserted during an issue cycle → next cycle all valids are 0 and the queue is empty. The instruction pushed after flush issues two edges later.
6. Fill and drain 9 instructions back-to-back with no back-pressure → each issues once, in order, and pointers wrap correctly.
